wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the ares-riscv core.
- Accepts completed instructions from the MEM stage over a valid/ready handshake.
- Selects the write-back source: ALU result, PC+4, or formatted load data. Load data arrives from data memory with variable latency.
- Drives the register file write port (RegWEn/AddrD/DataD) from registered outputs.

Parameters:
- XLEN, 32, data width of results and register write data
- REG_AW, 5, register address width

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous reset, active-low
- valid_i  in  1  MEM stage presents an instruction
- ready_o  out  1  stage can accept an instruction this cycle
- RegWEn_i  in  1  instruction writes rd
- AddrD_i  in  REG_AW  rd address
- WbSel_i  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 none
- AluRes_i  in  XLEN  ALU result; for loads, the byte address
- PcPlus4_i  in  XLEN  PC+4 of the instruction
- LoadFunct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- DmemRvalid_i  in  1  data memory read response valid
- DmemRdata_i  in  XLEN  aligned 32-bit word read from memory
- RegWEn_o  out  1  register file write enable, one-cycle pulse
- AddrD_o  out  REG_AW  register file write address
- DataD_o  out  XLEN  register file write data
- err_o  out  1  one-cycle pulse: misaligned or illegal load, write suppressed

Behaviour:
- Clock and reset: clk_i, single clock domain. rst_i is asynchronous active-low (0 = reset).
- Reset values:
  - state = IDLE; ready_o = 1
  - RegWEn_o = 0; AddrD_o = 0; DataD_o = 0; err_o = 0
  - All internal latches cleared.
- FSM states: IDLE and WAIT_LOAD. ready_o = 1 in IDLE, 0 in WAIT_LOAD.
- Accept condition: valid_i & ready_o.
- IDLE, accept with WbSel_i = 00 / 10 / 11:
  - Next edge: RegWEn_o = RegWEn_i & (AddrD_i != 0) & (WbSel_i != 11).
  - AddrD_o = AddrD_i.
  - DataD_o = AluRes_i (00) or PcPlus4_i (10); unchanged for 11.
  - Stay in IDLE. Latency is 1 cycle, and back-to-back accepts are allowed every cycle.
- IDLE, accept with WbSel_i = 01:
  - Latch AddrD_i, RegWEn_i, LoadFunct3_i and offset AluRes_i[1:0].
  - Go to WAIT_LOAD.
- WAIT_LOAD:
  - Wait for DmemRvalid_i; no timeout.
  - On DmemRvalid_i, format the data and go to IDLE. Outputs are registered on that edge.
  - ready_o returns to 1 in the next cycle.
- Load formatting, with off = latched offset:
  - LB / LBU: byte DmemRdata_i[8*off+7 : 8*off], sign-extended (LB) or zero-extended (LBU).
  - LH / LHU: off must be 0 or 2; halfword [16*off/2+15 : 8*off], sign- or zero-extended.
  - LW: off must be 0.
- Load errors:
  - Misaligned cases: LH/LHU with off odd, LW with off != 0.
  - Illegal cases: funct3 of 011, 110 or 111.
  - On an error: RegWEn_o = 0, err_o = 1 for one cycle, DataD_o unchanged, return to IDLE.
- RegWEn_o and err_o are single-cycle pulses; they default to 0 on every edge with no event.
- AddrD_o and DataD_o hold their last value.
- Writes to x0 never assert RegWEn_o.
- DmemRvalid_i in IDLE is ignored: no state change, no write.
- DmemRvalid_i is accepted no earlier than the cycle after the load is accepted.
- Reset asserted mid-WAIT_LOAD: the pending load is abandoned. After reset, any late DmemRvalid_i is ignored because the FSM is in IDLE.
- The register file forwards DataD combinationally, so no hazard logic is required here.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret_o, 64 bits: a retire counter, reset to 0.
  - Increments by 1 on each non-load accept.
  - Increments by 1 on each load completion without error; x0 destinations still count.
  - Wraps modulo 2^64.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then valid_i=1, WbSel=00, AddrD=5, AluRes=0x1234_5678:
  - Next cycle RegWEn_o=1, AddrD_o=5, DataD_o=0x1234_5678.
  - The cycle after, RegWEn_o=0.
- WbSel=10, AddrD=0, PcPlus4=0x0000_0104:
  - RegWEn_o stays 0.
  - AddrD_o=0, DataD_o=0x0000_0104.
- LB with addr offset 3, then 4-cycle delay, then DmemRdata=0x80FF_0011:
  - ready_o=0 for 4 cycles.
  - Then DataD_o=0xFFFF_FF80, RegWEn_o=1.
  - With LBU instead: 0x0000_0080.
- LHU offset 2 on word 0xBEEF_1234 -> DataD_o=0x0000_BEEF.
  - LW offset 1 -> err_o pulse, RegWEn_o=0, back in IDLE.
- Reset mid-wait:
  - Assert rst_i=0 during WAIT_LOAD -> ready_o=1 and RegWEn_o=0 immediately.
  - A following DmemRvalid_i=1 is ignored.
- With WB_RETIRE_CNT_EN: 3 ALU ops, 1 good load and 1 misaligned load -> instret_o=4.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: selects ALU / PC+4 / formatted load data and drives the register file write port.
// Optional retire counter output instret_o is enabled with `define WB_RETIRE_CNT_EN.
module wb_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              RegWEn_i,
   input  logic [REG_AW-1:0] AddrD_i,
   input  logic [1:0]        WbSel_i,
   input  logic [XLEN-1:0]   AluRes_i,
   input  logic [XLEN-1:0]   PcPlus4_i,
   input  logic [2:0]        LoadFunct3_i,
   input  logic              DmemRvalid_i,
   input  logic [XLEN-1:0]   DmemRdata_i,
   output logic              RegWEn_o,
   output logic [REG_AW-1:0] AddrD_o,
   output logic [XLEN-1:0]   DataD_o,
   output logic              err_o
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0]       instret_o
`endif
);

   typedef enum logic {IDLE, WAIT_LOAD} state_e;

   state_e            state_q, state_d;
   logic              ld_wen_q, ld_wen_d;
   logic [REG_AW-1:0] ld_addr_q, ld_addr_d;
   logic [2:0]        ld_f3_q, ld_f3_d;
   logic [1:0]        ld_off_q, ld_off_d;
   logic              regwen_q, regwen_d;
   logic [REG_AW-1:0] addrd_q, addrd_d;
   logic [XLEN-1:0]   datad_q, datad_d;
   logic              err_q, err_d;

   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [XLEN-1:0]   ld_fmt;
   logic              ld_err;
   logic              accept;

   assign ready_o  = (state_q == IDLE);
   assign accept   = valid_i & ready_o;
   assign RegWEn_o = regwen_q;
   assign AddrD_o  = addrd_q;
   assign DataD_o  = datad_q;
   assign err_o    = err_q;

   // Load formatting uses the offset and funct3 latched at accept time.
   always_comb begin
      ld_byte = DmemRdata_i[{ld_off_q, 3'b000} +: 8];
      ld_half = ld_off_q[1] ? DmemRdata_i[31:16] : DmemRdata_i[15:0];
      ld_fmt  = '0;
      ld_err  = 1'b0;
      case (ld_f3_q)
         3'b000: ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100: ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001: begin
            ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            ld_err = ld_off_q[0];
         end
         3'b101: begin
            ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            ld_err = ld_off_q[0];
         end
         3'b010: begin
            ld_fmt = DmemRdata_i;
            ld_err = (ld_off_q != 2'b00);
         end
         default: ld_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ld_wen_d  = ld_wen_q;
      ld_addr_d = ld_addr_q;
      ld_f3_d   = ld_f3_q;
      ld_off_d  = ld_off_q;
      regwen_d  = 1'b0;
      addrd_d   = addrd_q;
      datad_d   = datad_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WbSel_i == 2'b01) begin
                  ld_wen_d  = RegWEn_i;
                  ld_addr_d = AddrD_i;
                  ld_f3_d   = LoadFunct3_i;
                  ld_off_d  = AluRes_i[1:0];
                  state_d   = WAIT_LOAD;
               end else begin
                  regwen_d = RegWEn_i & (AddrD_i != '0) & (WbSel_i != 2'b11);
                  addrd_d  = AddrD_i;
                  if (WbSel_i == 2'b00)
                     datad_d = AluRes_i;
                  else if (WbSel_i == 2'b10)
                     datad_d = PcPlus4_i;
               end
            end
         end
         WAIT_LOAD: begin
            if (DmemRvalid_i) begin
               state_d = IDLE;
               if (ld_err) begin
                  err_d = 1'b1;
               end else begin
                  regwen_d = ld_wen_q & (ld_addr_q != '0);
                  addrd_d  = ld_addr_q;
                  datad_d  = ld_fmt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         ld_wen_q  <= 1'b0;
         ld_addr_q <= '0;
         ld_f3_q   <= '0;
         ld_off_q  <= '0;
         regwen_q  <= 1'b0;
         addrd_q   <= '0;
         datad_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_wen_q  <= ld_wen_d;
         ld_addr_q <= ld_addr_d;
         ld_f3_q   <= ld_f3_d;
         ld_off_q  <= ld_off_d;
         regwen_q  <= regwen_d;
         addrd_q   <= addrd_d;
         datad_q   <= datad_d;
         err_q     <= err_d;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Non-load accepts retire immediately; loads retire only on error-free completion.
   logic        retire;
   logic [63:0] instret_q;

   assign retire    = (accept & (WbSel_i != 2'b01)) |
                      ((state_q == WAIT_LOAD) & DmemRvalid_i & ~ld_err);
   assign instret_o = instret_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         instret_q <= '0;
      else if (retire)
         instret_q <= instret_q + 64'd1;
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; covers ALU/PC+4 write-back, load formatting,
// load errors, x0 suppression, IDLE rvalid and reset during a pending load.
module tb_wb_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        RegWEn_i = 1'b0;
   logic [4:0]  AddrD_i = '0;
   logic [1:0]  WbSel_i = '0;
   logic [31:0] AluRes_i = '0;
   logic [31:0] PcPlus4_i = '0;
   logic [2:0]  LoadFunct3_i = '0;
   logic        DmemRvalid_i = 1'b0;
   logic [31:0] DmemRdata_i = '0;
   logic        RegWEn_o;
   logic [4:0]  AddrD_o;
   logic [31:0] DataD_o;
   logic        err_o;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] instret_o;
`endif

   int n_compared   = 0;
   int n_mismatched = 0;

   wb_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .RegWEn_i     (RegWEn_i),
      .AddrD_i      (AddrD_i),
      .WbSel_i      (WbSel_i),
      .AluRes_i     (AluRes_i),
      .PcPlus4_i    (PcPlus4_i),
      .LoadFunct3_i (LoadFunct3_i),
      .DmemRvalid_i (DmemRvalid_i),
      .DmemRdata_i  (DmemRdata_i),
      .RegWEn_o     (RegWEn_o),
      .AddrD_o      (AddrD_o),
      .DataD_o      (DataD_o),
      .err_o        (err_o)
`ifdef WB_RETIRE_CNT_EN
      ,
      .instret_o    (instret_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic issue(input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
      valid_i      = 1'b1;
      WbSel_i      = sel;
      RegWEn_i     = wen;
      AddrD_i      = rd;
      AluRes_i     = alu;
      PcPlus4_i    = pc;
      LoadFunct3_i = f3;
      @(negedge clk_i);
      valid_i = 1'b0;
   endtask

   // Holds off the response for 'delay' cycles in WAIT_LOAD, response on the last one.
   task automatic respond(input logic [31:0] data, input int delay);
      for (int i = 0; i < delay; i++) begin
         chk("wait_ready", {63'd0, ready_o}, 64'd0);
         if (i == delay - 1) begin
            DmemRvalid_i = 1'b1;
            DmemRdata_i  = data;
         end
         @(negedge clk_i);
      end
      DmemRvalid_i = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic wen, input logic [4:0] rd,
                             input logic [31:0] data, input logic err);
      chk({tag, "_wen"},   {63'd0, RegWEn_o}, {63'd0, wen});
      chk({tag, "_addr"},  {59'd0, AddrD_o},  {59'd0, rd});
      chk({tag, "_data"},  {32'd0, DataD_o},  {32'd0, data});
      chk({tag, "_err"},   {63'd0, err_o},    {63'd0, err});
      chk({tag, "_ready"}, {63'd0, ready_o},  64'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      expect_out("reset", 1'b0, 5'd0, 32'h0, 1'b0);
      rst_i = 1'b1;
      @(negedge clk_i);

      // ALU result, then pulse drops
      issue(2'b00, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 3'b000);
      expect_out("alu", 1'b1, 5'd5, 32'h1234_5678, 1'b0);
      @(negedge clk_i);
      expect_out("alu_idle", 1'b0, 5'd5, 32'h1234_5678, 1'b0);

      // PC+4 to x0
      issue(2'b10, 1'b1, 5'd0, 32'h0, 32'h0000_0104, 3'b000);
      expect_out("pc4_x0", 1'b0, 5'd0, 32'h0000_0104, 1'b0);

      // back-to-back ALU ops, then WbSel=11
      valid_i = 1'b1; WbSel_i = 2'b00; RegWEn_i = 1'b1; AddrD_i = 5'd7; AluRes_i = 32'hA;
      @(negedge clk_i);
      expect_out("b2b_0", 1'b1, 5'd7, 32'hA, 1'b0);
      AddrD_i = 5'd8; AluRes_i = 32'hB;
      @(negedge clk_i);
      expect_out("b2b_1", 1'b1, 5'd8, 32'hB, 1'b0);
      issue(2'b11, 1'b1, 5'd9, 32'hC, 32'hD, 3'b000);
      expect_out("none", 1'b0, 5'd9, 32'hB, 1'b0);
      RegWEn_i = 1'b0;

      // LB offset 3 after 4-cycle delay
      issue(2'b01, 1'b1, 5'd10, 32'h0000_1003, 32'h0, 3'b000);
      respond(32'h80FF_0011, 4);
      expect_out("lb", 1'b1, 5'd10, 32'hFFFF_FF80, 1'b0);
      @(negedge clk_i);
      chk("lb_pulse", {63'd0, RegWEn_o}, 64'd0);

      issue(2'b01, 1'b1, 5'd11, 32'h0000_1003, 32'h0, 3'b100);
      respond(32'h80FF_0011, 2);
      expect_out("lbu", 1'b1, 5'd11, 32'h0000_0080, 1'b0);

      issue(2'b01, 1'b1, 5'd12, 32'h0000_2002, 32'h0, 3'b101);
      respond(32'hBEEF_1234, 1);
      expect_out("lhu", 1'b1, 5'd12, 32'h0000_BEEF, 1'b0);

      issue(2'b01, 1'b1, 5'd13, 32'h0000_2000, 32'h0, 3'b001);
      respond(32'hBEEF_8234, 1);
      expect_out("lh", 1'b1, 5'd13, 32'hFFFF_8234, 1'b0);

      issue(2'b01, 1'b1, 5'd14, 32'h0000_3000, 32'h0, 3'b010);
      respond(32'hDEAD_BEEF, 3);
      expect_out("lw", 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0);

      // Errors leave address and data untouched
      issue(2'b01, 1'b1, 5'd15, 32'h0000_3001, 32'h0, 3'b010);
      respond(32'h1111_1111, 1);
      expect_out("lw_mis", 1'b0, 5'd14, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk_i);
      chk("err_pulse", {63'd0, err_o}, 64'd0);

      issue(2'b01, 1'b1, 5'd16, 32'h0000_3001, 32'h0, 3'b001);
      respond(32'h2222_2222, 1);
      expect_out("lh_mis", 1'b0, 5'd14, 32'hDEAD_BEEF, 1'b1);

      issue(2'b01, 1'b1, 5'd17, 32'h0000_3000, 32'h0, 3'b011);
      respond(32'h3333_3333, 1);
      expect_out("illegal", 1'b0, 5'd14, 32'hDEAD_BEEF, 1'b1);

      // Load to x0 formats data but never writes
      issue(2'b01, 1'b1, 5'd0, 32'h0000_3000, 32'h0, 3'b010);
      respond(32'h5555_AAAA, 1);
      expect_out("ld_x0", 1'b0, 5'd0, 32'h5555_AAAA, 1'b0);

      // rvalid in IDLE is ignored
      DmemRvalid_i = 1'b1; DmemRdata_i = 32'h7777_7777;
      @(negedge clk_i);
      DmemRvalid_i = 1'b0;
      expect_out("idle_rvalid", 1'b0, 5'd0, 32'h5555_AAAA, 1'b0);

      // Reset during WAIT_LOAD abandons the load
      issue(2'b01, 1'b1, 5'd20, 32'h0000_4000, 32'h0, 3'b010);
      chk("pre_rst_ready", {63'd0, ready_o}, 64'd0);
      #2 rst_i = 1'b0;
      #1;
      expect_out("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b1;
      DmemRvalid_i = 1'b1; DmemRdata_i = 32'h9999_9999;
      @(negedge clk_i);
      DmemRvalid_i = 1'b0;
      expect_out("late_rvalid", 1'b0, 5'd0, 32'h0, 1'b0);

`ifdef WB_RETIRE_CNT_EN
      chk("instret_rst", instret_o, 64'd0);
      issue(2'b00, 1'b1, 5'd1, 32'h1, 32'h0, 3'b000);
      issue(2'b00, 1'b1, 5'd2, 32'h2, 32'h0, 3'b000);
      issue(2'b00, 1'b1, 5'd3, 32'h3, 32'h0, 3'b000);
      issue(2'b01, 1'b1, 5'd4, 32'h0, 32'h0, 3'b010);
      respond(32'h4444_4444, 1);
      issue(2'b01, 1'b1, 5'd5, 32'h1, 32'h0, 3'b010);
      respond(32'h5555_5555, 1);
      chk("instret", instret_o, 64'd4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
